// File: rtl/hex_display_arbiter.sv
// Shares the HEX0_3 seven-segment PIO between two requesters. The winning value is decoded
// to four active-low digits, optionally blinked, and written out over an Avalon-MM write master.
module hex_display_arbiter #(
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   input  logic        req0_blink,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   input  logic        req1_blink,
   output logic        req1_ready,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        owner,
   output logic [1:0]  state_dbg
);

   localparam int            CW         = $clog2(BLINK_CYCLES);
   localparam logic [CW-1:0] LAST_CNT   = CW'(BLINK_CYCLES - 1);
   localparam logic [31:0]   BLANK_WORD = 32'h0FFF_FFFF;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_WRITE = 2'd2,
      S_SHOW  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          last_grant;
   logic          ret_show;
   logic          blink_en;
   logic          phase_blank;
   logic [CW-1:0] blink_cnt;
   logic [15:0]   shown_data;

   logic          any_req;
   logic          can_accept;
   logic          expire;
   logic          grant;
   logic          accept;
   logic          toggle;
   logic [15:0]   grant_data;
   logic          grant_blink;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] digits(input logic [15:0] v);
      return {4'b0000, seg7(v[15:12]), seg7(v[11:8]), seg7(v[7:4]), seg7(v[3:0])};
   endfunction

   assign any_req    = req0_valid | req1_valid;
   assign can_accept = (state == S_IDLE) || (state == S_SHOW);
   assign expire     = (state == S_SHOW) && blink_en && (blink_cnt == LAST_CNT);
   assign m_address  = 2'b00;
   assign state_dbg  = state;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  state_nxt = S_WRITE;
         S_IDLE:  if (any_req) state_nxt = S_WRITE;
         S_WRITE: if (!m_waitrequest) state_nxt = ret_show ? S_SHOW : S_IDLE;
         S_SHOW:  if (any_req || expire) state_nxt = S_WRITE;
         default: state_nxt = S_INIT;
      endcase
   end

   // Handshake: a requester holds reqN_valid (with data/blink stable) until it sees
   // reqN_ready high; the value is taken on the rising edge where valid and ready are
   // both high. Ready is only offered in IDLE/SHOW, and to at most one requester.
   always_comb begin
      grant       = 1'b0;
      accept      = 1'b0;
      toggle      = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      grant_data  = req0_data;
      grant_blink = req0_blink;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else begin
         grant = req1_valid;
      end
      if (grant) begin
         grant_data  = req1_data;
         grant_blink = req1_blink;
      end
      if (can_accept && any_req) begin
         accept     = 1'b1;
         req0_ready = ~grant;
         req1_ready = grant;
      end else if (expire) begin
         toggle = 1'b1;
      end
   end

   // Registered master outputs and display context. A new request outranks a blink
   // expiry in the same cycle because accept already suppresses toggle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= 32'h0;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         ret_show     <= 1'b0;
         blink_en     <= 1'b0;
         phase_blank  <= 1'b0;
         blink_cnt    <= '0;
         shown_data   <= 16'h0;
      end else begin
         if (state == S_INIT) begin
            m_writedata  <= BLANK_WORD;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            ret_show     <= 1'b0;
         end else if (accept) begin
            owner        <= grant;
            last_grant   <= grant;
            shown_data   <= grant_data;
            blink_en     <= grant_blink;
            phase_blank  <= 1'b0;
            blink_cnt    <= '0;
            m_writedata  <= digits(grant_data);
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            ret_show     <= 1'b1;
         end else if (state == S_WRITE) begin
            if (!m_waitrequest) begin
               m_chipselect <= 1'b0;
               m_write_n    <= 1'b1;
            end
         end else if (toggle) begin
            blink_cnt    <= '0;
            phase_blank  <= ~phase_blank;
            m_writedata  <= phase_blank ? digits(shown_data) : BLANK_WORD;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            ret_show     <= 1'b1;
         end else if ((state == S_SHOW) && blink_en) begin
            blink_cnt <= blink_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: directed vector table, hand-built blink/stall/reset
// sequences, and randomized requests checked against a transaction-level model.
module tb_hex_display_arbiter;

   localparam int          BLINK = 8;
   localparam logic [31:0] BLANK = 32'h0FFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_blink, req0_ready;
   logic        req1_valid, req1_blink, req1_ready;
   logic [15:0] req0_data, req1_data;
   logic [1:0]  m_address;
   logic        m_chipselect, m_write_n, m_waitrequest;
   logic [31:0] m_writedata;
   logic        owner;
   logic [1:0]  state_dbg;

   hex_display_arbiter #(.BLINK_CYCLES(BLINK)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_blink(req0_blink), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_blink(req1_blink), .req1_ready(req1_ready),
      .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
      .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
      .owner(owner), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_q[$];
   logic [31:0] obs_data[$];
   int          obs_cyc[$];
   int          obs_len[$];
   logic        m_last = 1'b1;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic logic [31:0] expect_word(input logic [15:0] v);
      return {4'b0000, seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
   endfunction

   function automatic logic model_grant(input logic v0, input logic v1);
      if (v0 && v1) return ~m_last;
      return v1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: write completions, strobe stability under stall, ready rules.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_wd    = 32'h0;
   int          cur_len    = 0;
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
         cur_len    = 0;
      end else begin
         check("strobe_pair", 32'(m_chipselect ^ m_write_n), 32'd1);
         if (req0_ready || req1_ready)
            check("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
         if (m_chipselect && !m_write_n) begin
            check("strobe_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
            check("address", 32'(m_address), 32'd0);
            if (prev_stall) check("stall_hold", m_writedata, prev_wd);
            cur_len++;
            if (m_waitrequest) begin
               prev_stall = 1'b1;
               prev_wd    = m_writedata;
            end else begin
               obs_data.push_back(m_writedata);
               obs_cyc.push_back(cyc);
               obs_len.push_back(cur_len);
               cur_len    = 0;
               prev_stall = 1'b0;
            end
         end else if (prev_stall) begin
            check("strobe_held", 32'(m_chipselect && !m_write_n), 32'd1);
            prev_stall = 1'b0;
            cur_len    = 0;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_cs"}, 32'(m_chipselect), 32'd0);
      check({name, "_wn"}, 32'(m_write_n), 32'd1);
      check({name, "_wd"}, m_writedata, 32'd0);
      check({name, "_addr"}, 32'(m_address), 32'd0);
      check({name, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
      check({name, "_owner"}, 32'(owner), 32'd0);
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
   task automatic request(input logic v0, input logic v1, input logic [15:0] d0, input logic [15:0] d1,
                          input logic b0, input logic b1, input logic exp_g, input string name,
                          output int acc);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      acc  = -1;
      req0_valid = v0; req0_data = d0; req0_blink = b0;
      req1_valid = v1; req1_data = d1; req1_blink = b1;
      while (!seen && n < 20) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            seen = 1'b1;
            acc  = cyc;
            check({name, "_grant"}, 32'({req1_ready, req0_ready}), exp_g ? 32'd2 : 32'd1);
         end
         n++;
         next_cycle();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check({name, "_accepted"}, 32'(seen), 32'd1);
      check({name, "_owner"}, 32'(owner), 32'(exp_g));
      m_last = exp_g;
   endtask

   task automatic check_write(input string name, input int exp_len, output int done_cyc);
      int          n;
      logic [31:0] e;
      n        = 0;
      done_cyc = -1;
      while (obs_data.size() == 0 && n < 64) begin
         next_cycle();
         n++;
      end
      check({name, "_write_seen"}, 32'(obs_data.size() != 0), 32'd1);
      if (obs_data.size() != 0) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check({name, "_data"}, obs_data.pop_front(), e);
         check({name, "_len"}, 32'(obs_len.pop_front()), 32'(exp_len));
         done_cyc = obs_cyc.pop_front();
      end
   endtask

   task automatic quiet(input int n, input string name);
      repeat (n) next_cycle();
      check({name, "_no_extra_write"}, 32'(obs_data.size()), 32'd0);
   endtask

   typedef struct {
      logic        v0, v1;
      logic [15:0] d0, d1;
      logic        b0, b1;
      logic        g;
      logic [31:0] wd;
      int          hold;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int          c, c0, c1, c2, c3, c4, acc, pat, stall;
      logic        v0, v1, b0, b1, g;
      logic [15:0] d0, d1;
      logic [31:0] wd;

      tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0F29_1819, 100};
      tbl[1] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h01C3_870E, 10};
      tbl[2] = '{1'b1, 1'b1, 16'h8888, 16'h5555, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 10};
      tbl[3] = '{1'b1, 1'b1, 16'h1111, 16'h5678, 1'b0, 1'b0, 1'b1, 32'h0240_BC00, 10};
      tbl[4] = '{1'b1, 1'b1, 16'h9ABC, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0202_01C6, 10};
      tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'hDE07, 1'b0, 1'b0, 1'b1, 32'h0421_A078, 10};
      tbl[6] = '{1'b1, 1'b0, 16'h3210, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0609_3CC0, 10};

      // Clock/reset.
      reset = 1'b1;
      req0_valid = 1'b0; req0_data = 16'h0; req0_blink = 1'b0;
      req1_valid = 1'b0; req1_data = 16'h0; req1_blink = 1'b0;
      m_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      exp_q.push_back(BLANK);
      check_write("init_blank", 1, c);
      quiet(20, "init_idle");

      // Directed vectors: single requester, then alternating round-robin.
      for (int i = 0; i < 7; i++) begin
         request(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].b0, tbl[i].b1, tbl[i].g,
                 $sformatf("vec%0d", i), acc);
         exp_q.push_back(tbl[i].wd);
         check_write($sformatf("vec%0d", i), 1, c);
         check($sformatf("vec%0d_latency", i), 32'(c - acc), 32'd1);
         quiet(tbl[i].hold, $sformatf("vec%0d", i));
      end

      // Blink: value/blank alternation, then a request landing exactly on an expiry.
      wd = expect_word(16'hABCD);
      request(1'b0, 1'b1, 16'h0, 16'hABCD, 1'b0, 1'b1, model_grant(1'b0, 1'b1), "blink", acc);
      exp_q.push_back(wd);    check_write("blink_v0", 1, c0);
      exp_q.push_back(BLANK); check_write("blink_b0", 1, c1);
      check("blink_gap0", 32'(c1 - c0), 32'(BLINK + 1));
      exp_q.push_back(wd);    check_write("blink_v1", 1, c2);
      check("blink_gap1", 32'(c2 - c1), 32'(BLINK + 1));
      while (cyc < c2 + BLINK) next_cycle();
      request(1'b1, 1'b0, 16'h0C0F, 16'h0, 1'b1, 1'b0, model_grant(1'b1, 1'b0), "expiry_req", acc);
      check("expiry_req_cycle", 32'(acc), 32'(c2 + BLINK));
      exp_q.push_back(expect_word(16'h0C0F)); check_write("expiry_val", 1, c3);
      check("expiry_latency", 32'(c3 - acc), 32'd1);
      exp_q.push_back(BLANK); check_write("expiry_blank", 1, c4);
      check("expiry_gap", 32'(c4 - c3), 32'(BLINK + 1));
      request(1'b0, 1'b1, 16'h0, 16'h7E57, 1'b0, 1'b0, model_grant(1'b0, 1'b1), "unblink", acc);
      exp_q.push_back(expect_word(16'h7E57)); check_write("unblink", 1, c);
      quiet(30, "unblink");

      // Waitrequest held for 5 cycles with both requesters pressing.
      request(1'b1, 1'b0, 16'h4321, 16'h0, 1'b0, 1'b0, model_grant(1'b1, 1'b0), "stall", acc);
      m_waitrequest = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (5) next_cycle();
      m_waitrequest = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp_q.push_back(expect_word(16'h4321));
      check_write("stall", 6, c);
      quiet(10, "stall");

      // Reset in the middle of a write strobe.
      request(1'b0, 1'b1, 16'h0, 16'hBEEF, 1'b0, 1'b0, model_grant(1'b0, 1'b1), "rstwr", acc);
      #1 reset = 1'b1;
      #1;
      check_idle_outputs("midwrite_reset");
      m_last = 1'b1;
      exp_q.delete();
      next_cycle();
      next_cycle();
      reset = 1'b0;
      exp_q.push_back(BLANK);
      check_write("rst_init", 1, c);
      quiet(15, "rst_idle");

      // Randomized requests against the transaction-level model.
      for (int it = 0; it < 40; it++) begin
         pat   = $urandom_range(1, 3);
         v0    = pat[0];
         v1    = pat[1];
         d0    = 16'($urandom);
         d1    = 16'($urandom);
         b0    = ($urandom_range(0, 3) == 0);
         b1    = ($urandom_range(0, 3) == 0);
         stall = $urandom_range(0, 3);
         g     = model_grant(v0, v1);
         request(v0, v1, d0, d1, b0, b1, g, $sformatf("rnd%0d", it), acc);
         if (stall > 0) begin
            m_waitrequest = 1'b1;
            repeat (stall) next_cycle();
            m_waitrequest = 1'b0;
         end
         exp_q.push_back(expect_word(g ? d1 : d0));
         check_write($sformatf("rnd%0d", it), stall + 1, c0);
         if (g ? b1 : b0) begin
            exp_q.push_back(BLANK);
            check_write($sformatf("rnd%0d_blank", it), 1, c1);
            check($sformatf("rnd%0d_gap", it), 32'(c1 - c0), 32'(BLINK + 1));
         end else begin
            quiet($urandom_range(1, 6), $sformatf("rnd%0d", it));
         end
      end

      quiet(5, "final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
